// File: rtl/hazard_pkg.sv
// Shared hazard-control types and constants for the pipeline control slice.
package hazard_pkg;

   // Memory-wait FSM states of the stall unit
   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MEMWAIT = 2'd1,
      ST_ABORT   = 2'd2
   } hz_state_t;

   // Forwarding mux selects, shared with the forwarding unit
   localparam logic [1:0] FW_NONE  = 2'd0;
   localparam logic [1:0] FW_EXMEM = 2'd1;
   localparam logic [1:0] FW_MEMWB = 2'd2;

   // Load-use hazard: a load in EX writes a register the ID instruction reads.
   // $zero never matches, mirroring the forwarding unit's rule.
   function automatic logic load_use_hazard(
      input logic       mem_read_ex,
      input logic [4:0] dst_ex,
      input logic [4:0] rs_id,
      input logic [4:0] rt_id,
      input logic       uses_rt_id
   );
      return mem_read_ex && (dst_ex != 5'd0) &&
             ((dst_ex == rs_id) || (uses_rt_id && (dst_ex == rt_id)));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   // Count enabled cycles, stopping at the maximum value instead of wrapping
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard control: load-use stalls, branch/jump flushes, data-memory
// wait freezes with timeout abort, and a saturating stall-cycle counter.
module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MemRead_IDEX,
   input  logic [4:0]       Write_Register_IDEX,
   input  logic [4:0]       Read_register1,
   input  logic [4:0]       Read_register2,
   input  logic             Uses_rt_ID,
   input  logic             Branch_Taken_EX,
   input  logic             Jump_ID,
   input  logic             Mem_Busy,
   output logic             PC_Write,
   output logic             IFID_Write,
   output logic             IFID_Flush,
   output logic             IDEX_Bubble,
   output logic             IDEX_Write,
   output logic             EXMEM_Write,
   output logic             Mem_Timeout,
   output logic [CNT_W-1:0] Stall_Count
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   hz_state_t         r_state;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic              r_mem_timeout;

   logic              w_lu;
   logic              w_freeze;
   logic              w_stall_inc;
   logic [CNT_W-1:0]  w_stall_count;

   // Memory-wait FSM: count busy cycles, abort after MEM_TIMEOUT, pulse Mem_Timeout in ABORT
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_RUN;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         r_mem_timeout <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (Mem_Busy) begin
                  r_state    <= ST_MEMWAIT;
                  r_wait_cnt <= WAIT_W'(1);
               end
            end
            ST_MEMWAIT: begin
               if (!Mem_Busy) begin
                  r_state    <= ST_RUN;
                  r_wait_cnt <= '0;
               end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                  r_state       <= ST_ABORT;
                  r_wait_cnt    <= '0;
                  r_mem_timeout <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
               end
            end
            ST_ABORT: begin
               r_state <= ST_RUN;
            end
            default: begin
               r_state    <= ST_RUN;
               r_wait_cnt <= '0;
            end
         endcase
      end
   end

   // Same-cycle control decode; freeze beats branch beats load-use beats jump
   always_comb begin
      w_lu = load_use_hazard(MemRead_IDEX, Write_Register_IDEX, Read_register1,
                             Read_register2, Uses_rt_ID);
      // Reset, ABORT and any busy cycle freeze; the MEMWAIT exit cycle (busy low) runs normally
      w_freeze = !reset || (r_state == ST_ABORT) || Mem_Busy;

      PC_Write    = 1'b1;
      IFID_Write  = 1'b1;
      IFID_Flush  = 1'b0;
      IDEX_Bubble = 1'b0;
      IDEX_Write  = 1'b1;
      EXMEM_Write = 1'b1;

      if (w_freeze) begin
         PC_Write    = 1'b0;
         IFID_Write  = 1'b0;
         IDEX_Write  = 1'b0;
         EXMEM_Write = 1'b0;
      end else if (Branch_Taken_EX) begin
         IFID_Flush  = 1'b1;
         IDEX_Bubble = 1'b1;
      end else if (w_lu) begin
         PC_Write    = 1'b0;
         IFID_Write  = 1'b0;
         IDEX_Bubble = 1'b1;
      end else if (Jump_ID) begin
         IFID_Flush  = 1'b1;
      end
   end

   assign w_stall_inc = ~PC_Write;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_inc   (w_stall_inc),
      .i_clr   (1'b0),
      .o_count (w_stall_count)
   );

   assign Mem_Timeout = r_mem_timeout;
   assign Stall_Count = w_stall_count;

endmodule
